// File: rtl/processor_mc_core.sv
// processor_mc_core: multicycle core with a fetch/decode/exec/mem/wb state machine,
// a 64-entry register file, a wrapping program counter, halt and a retired counter.
// Ports:
//   clk, clkreset (async active-low)
//   imem_addr/imem_rdata         : instruction memory (combinational read, addr = pc)
//   dmem_req/we/addr/wdata       : data memory request, held until dmem_ready
//   dmem_rdata/dmem_ready        : data memory response
//   pc, halted, retired          : architectural status
module processor_mc_core #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned PC_W   = 6
) (
   input  logic              clk,
   input  logic              clkreset,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic [PC_W-1:0]   pc,
   output logic              halted,
   output logic [31:0]       retired
);

   localparam int unsigned NREGS = 64;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [3:0] OP_R    = 4'd0;
   localparam logic [3:0] OP_ADDI = 4'd1;
   localparam logic [3:0] OP_LW   = 4'd2;
   localparam logic [3:0] OP_SW   = 4'd3;
   localparam logic [3:0] OP_BEQ  = 4'd4;
   localparam logic [3:0] OP_JMP  = 4'd5;
   localparam logic [3:0] OP_HALT = 4'd6;

   logic [2:0]        state, state_n;
   logic [31:0]       ir, ir_n;
   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] rs_q, rs_n, rt_q, rt_n, rd_q, rd_n, imm_q, imm_n, res_q, res_n;
   logic [PC_W-1:0]   pc_n, pc_inc;
   logic [31:0]       retired_n;
   logic              halted_n;
   logic              dmem_req_n, dmem_we_n;
   logic [DATA_W-1:0] dmem_addr_n, dmem_wdata_n;
   logic [DATA_W-1:0] alu_c;

   logic [3:0] op, funct;
   logic [5:0] rd_idx, rs_idx, rt_idx;
   logic       unused_ir;

   assign op        = ir[31:28];
   assign rd_idx    = ir[27:22];
   assign rs_idx    = ir[21:16];
   assign rt_idx    = ir[15:10];
   assign funct     = ir[3:0];
   assign unused_ir = ^ir[9:4];
   assign imem_addr = pc;
   assign pc_inc    = pc + PC_W'(1);

   // R-type ALU on the operands latched in DECODE
   always_comb begin
      alu_c = '0;
      case (funct)
         4'd0:    alu_c = rs_q + rt_q;
         4'd1:    alu_c = rs_q - rt_q;
         4'd2:    alu_c = rs_q & rt_q;
         4'd3:    alu_c = rs_q | rt_q;
         4'd4:    alu_c = rs_q ^ rt_q;
         4'd5:    alu_c = {{(DATA_W-1){1'b0}}, ($signed(rs_q) < $signed(rt_q))};
         4'd6:    alu_c = rs_q << rt_q[4:0];
         4'd7:    alu_c = rs_q >> rt_q[4:0];
         default: alu_c = '0;
      endcase
   end

   // Next-state and datapath/output next values
   always_comb begin
      state_n      = state;
      ir_n         = ir;
      rs_n         = rs_q;
      rt_n         = rt_q;
      rd_n         = rd_q;
      imm_n        = imm_q;
      res_n        = res_q;
      pc_n         = pc;
      retired_n    = retired;
      halted_n     = halted;
      dmem_req_n   = dmem_req;
      dmem_we_n    = dmem_we;
      dmem_addr_n  = dmem_addr;
      dmem_wdata_n = dmem_wdata;
      case (state)
         S_FETCH: begin
            ir_n    = imem_rdata;
            state_n = S_DECODE;
         end
         S_DECODE: begin
            rs_n  = (rs_idx == 6'd0) ? '0 : regs[rs_idx];
            rt_n  = (rt_idx == 6'd0) ? '0 : regs[rt_idx];
            rd_n  = (rd_idx == 6'd0) ? '0 : regs[rd_idx];
            imm_n = {{(DATA_W-15){ir[14]}}, ir[14:0]};
            if (op == OP_HALT) begin
               halted_n  = 1'b1;
               retired_n = retired + 32'd1;
               state_n   = S_HALT;
            end else if (op > OP_HALT) begin
               pc_n      = pc_inc;
               retired_n = retired + 32'd1;
               state_n   = S_FETCH;
            end else begin
               state_n = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op)
               OP_R: begin
                  res_n   = alu_c;
                  state_n = S_WB;
               end
               OP_ADDI: begin
                  res_n   = rs_q + imm_q;
                  state_n = S_WB;
               end
               OP_LW, OP_SW: begin
                  dmem_req_n   = 1'b1;
                  dmem_we_n    = (op == OP_SW);
                  dmem_addr_n  = rs_q + imm_q;
                  dmem_wdata_n = rd_q;
                  state_n      = S_MEM;
               end
               OP_BEQ: begin
                  pc_n      = (rd_q == rs_q) ? pc_inc + imm_q[PC_W-1:0] : pc_inc;
                  retired_n = retired + 32'd1;
                  state_n   = S_FETCH;
               end
               OP_JMP: begin
                  pc_n      = imm_q[PC_W-1:0];
                  retired_n = retired + 32'd1;
                  state_n   = S_FETCH;
               end
               default: state_n = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (dmem_ready) begin
               dmem_req_n = 1'b0;
               if (dmem_we) begin
                  pc_n      = pc_inc;
                  retired_n = retired + 32'd1;
                  state_n   = S_FETCH;
               end else begin
                  res_n   = dmem_rdata;
                  state_n = S_WB;
               end
            end
         end
         S_WB: begin
            pc_n      = pc_inc;
            retired_n = retired + 32'd1;
            state_n   = S_FETCH;
         end
         S_HALT:  state_n = S_HALT;
         default: state_n = S_FETCH;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge clkreset) begin
      if (!clkreset) state <= S_FETCH;
      else           state <= state_n;
   end

   // Datapath, outputs and register file
   always_ff @(posedge clk or negedge clkreset) begin
      if (!clkreset) begin
         ir         <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         imm_q      <= '0;
         res_q      <= '0;
         pc         <= '0;
         retired    <= '0;
         halted     <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         for (int unsigned i = 0; i < NREGS; i++) regs[6'(i)] <= '0;
      end else begin
         ir         <= ir_n;
         rs_q       <= rs_n;
         rt_q       <= rt_n;
         rd_q       <= rd_n;
         imm_q      <= imm_n;
         res_q      <= res_n;
         pc         <= pc_n;
         retired    <= retired_n;
         halted     <= halted_n;
         dmem_req   <= dmem_req_n;
         dmem_we    <= dmem_we_n;
         dmem_addr  <= dmem_addr_n;
         dmem_wdata <= dmem_wdata_n;
         if (state == S_WB && rd_idx != 6'd0) regs[rd_idx] <= res_q;
      end
   end

endmodule

// File: tb/tb_processor_mc_core.sv
// tb_processor_mc_core: lockstep instruction-level model against processor_mc_core,
// directed programs from the test plan, randomized programs, and a 16/4 instance.
module tb_processor_mc_core;
   localparam int unsigned DW = 32;
   localparam int unsigned PW = 6;
   localparam int unsigned MW = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              clkreset;
   logic [PW-1:0]     imem_addr, pc;
   logic [31:0]       imem [64];
   logic [31:0]       imem_rdata;
   logic              dmem_req, dmem_we, dmem_ready, halted;
   logic [DW-1:0]     dmem_addr, dmem_wdata, dmem_rdata;
   logic [31:0]       retired;
   logic [DW-1:0]     ram [MW];

   assign imem_rdata = imem[imem_addr];

   processor_mc_core #(.DATA_W(DW), .PC_W(PW)) dut (
      .clk(clk), .clkreset(clkreset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .pc(pc), .halted(halted),
      .retired(retired));

   // Narrow instance: DATA_W=16, PC_W=4, memory always ready
   logic [3:0]  imem_addr2, pc2;
   logic [31:0] imem2 [16];
   logic [31:0] imem_rdata2, retired2;
   logic        req2, we2, halted2;
   logic [15:0] addr2, wdata2;
   assign imem_rdata2 = imem2[imem_addr2];

   processor_mc_core #(.DATA_W(16), .PC_W(4)) dut2 (
      .clk(clk), .clkreset(clkreset), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .dmem_req(req2), .dmem_we(we2), .dmem_addr(addr2), .dmem_wdata(wdata2),
      .dmem_rdata(16'h0000), .dmem_ready(1'b1), .pc(pc2), .halted(halted2),
      .retired(retired2));

   logic [15:0] st16 = 16'h0;
   logic [15:0] st16_addr = 16'h1234;
   bit          wrap16 = 1'b0;
   logic [3:0]  prev_pc2 = 4'd0;
   logic [31:0] prev_ret2 = 32'd0;
   always @(negedge clk) begin
      if (req2 && we2) begin
         st16      <= wdata2;
         st16_addr <= addr2;
      end
      if (prev_pc2 == 4'd15 && pc2 == 4'd0 && retired2 == prev_ret2 + 32'd1) wrap16 <= 1'b1;
      prev_pc2  <= pc2;
      prev_ret2 <= retired2;
   end

   // Reference model state
   logic [PW-1:0] m_pc;
   logic [DW-1:0] m_reg [64];
   logic [DW-1:0] m_mem [MW];
   logic [31:0]   m_ret;
   bit            m_halt;

   int n_checks = 0, n_pass = 0, n_fail = 0;
   int pc_hist[$];
   int cyc_hist[$];

   // Memory responder bookkeeping
   bit            resp_busy;
   int            waits_left, acc_waits, acc_reqcyc;
   logic          acc_we;
   logic [DW-1:0] acc_addr, acc_wdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fi(input int op, input int rd, input int rs, input int imm);
      return {4'(op), 6'(rd), 6'(rs), 1'b0, 15'(imm)};
   endfunction

   function automatic logic [31:0] fr(input int rd, input int rs, input int rt, input int fn);
      return {4'd0, 6'(rd), 6'(rs), 6'(rt), 6'd0, 4'(fn)};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = 32'h7000_0000;
   endtask

   // Execute one instruction of the architectural model
   task automatic m_step(output int cpi, output bit is_mem, output bit e_we,
                         output logic [DW-1:0] e_addr, output logic [DW-1:0] e_wd);
      logic [31:0]   ins;
      int            op, rd, rs, rt, fn, simm;
      logic [DW-1:0] a, b, d, imm, res;
      bit            wr;
      ins  = imem[m_pc];
      op   = int'(ins[31:28]);
      rd   = int'(ins[27:22]);
      rs   = int'(ins[21:16]);
      rt   = int'(ins[15:10]);
      fn   = int'(ins[3:0]);
      simm = int'($signed(ins[14:0]));
      imm  = DW'(simm);
      a = m_reg[rs]; b = m_reg[rt]; d = m_reg[rd];
      is_mem = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; wr = 1'b0; res = '0; cpi = 2;
      m_ret = m_ret + 32'd1;
      case (op)
         0: begin
            wr = 1'b1; cpi = 4;
            case (fn)
               0: res = a + b;
               1: res = a - b;
               2: res = a & b;
               3: res = a | b;
               4: res = a ^ b;
               5: res = ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
               6: res = a << b[4:0];
               7: res = a >> b[4:0];
               default: res = '0;
            endcase
         end
         1: begin wr = 1'b1; cpi = 4; res = a + imm; end
         2: begin
            is_mem = 1'b1; e_addr = a + imm; res = m_mem[e_addr[7:0]]; wr = 1'b1; cpi = 5;
         end
         3: begin
            is_mem = 1'b1; e_we = 1'b1; e_addr = a + imm; e_wd = d;
            m_mem[e_addr[7:0]] = d; cpi = 4;
         end
         4: cpi = 3;
         5: cpi = 3;
         6: m_halt = 1'b1;
         default: cpi = 2;
      endcase
      if (wr && rd != 0) m_reg[rd] = res;
      if (op == 4) m_pc = (d == a) ? PW'(m_pc + PW'(1) + imm[PW-1:0]) : PW'(m_pc + PW'(1));
      else if (op == 5) m_pc = imm[PW-1:0];
      else if (op != 6) m_pc = PW'(m_pc + PW'(1));
   endtask

   task automatic reset_core();
      clkreset   = 1'b0;
      dmem_ready = 1'b0;
      dmem_rdata = '0;
      resp_busy  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pc", 64'(pc), 64'(0));
      chk("rst_halted", 64'(halted), 64'(0));
      chk("rst_retired", 64'(retired), 64'(0));
      chk("rst_req", 64'(dmem_req), 64'(0));
      chk("rst_we", 64'(dmem_we), 64'(0));
      chk("rst_addr", 64'(dmem_addr), 64'(0));
      chk("rst_wdata", 64'(dmem_wdata), 64'(0));
      m_pc = '0; m_ret = '0; m_halt = 1'b0;
      for (int i = 0; i < 64; i++) m_reg[i] = '0;
      for (int i = 0; i < int'(MW); i++) m_mem[i] = ram[i];
      pc_hist.delete();
      cyc_hist.delete();
      clkreset = 1'b1;
   endtask

   // Run until n_instr retirements or HALT; wmode < 0 picks random wait states
   task automatic run(input int n_instr, input int wmode);
      int            done, cyc, cpi;
      bit            is_mem, e_we;
      logic [DW-1:0] e_addr, e_wd;
      logic [31:0]   prev_ret;
      done = 0; cyc = 0;
      prev_ret = retired;
      while (done < n_instr && !m_halt) begin
         @(negedge clk);
         cyc++;
         if (dmem_req) begin
            if (!resp_busy) begin
               resp_busy  = 1'b1;
               waits_left = (wmode < 0) ? int'($urandom_range(3, 0)) : wmode;
               acc_waits  = waits_left;
               acc_reqcyc = 0;
               acc_addr   = dmem_addr;
               acc_we     = dmem_we;
               acc_wdata  = dmem_wdata;
            end
            acc_reqcyc++;
            if (waits_left > 0) begin
               dmem_ready = 1'b0;
               waits_left--;
            end else begin
               dmem_ready = 1'b1;
               dmem_rdata = ram[dmem_addr[7:0]];
               if (dmem_we) ram[dmem_addr[7:0]] = dmem_wdata;
               resp_busy = 1'b0;
               chk("req_len", 64'(acc_reqcyc), 64'(acc_waits + 1));
               chk("addr_stable", 64'(dmem_addr), 64'(acc_addr));
            end
         end else begin
            dmem_ready = 1'($urandom_range(1, 0));
            dmem_rdata = DW'($urandom);
         end
         if (retired != prev_ret) begin
            m_step(cpi, is_mem, e_we, e_addr, e_wd);
            done++;
            chk("pc", 64'(pc), 64'(m_pc));
            chk("retired", 64'(retired), 64'(m_ret));
            chk("halted", 64'(halted), 64'(m_halt));
            chk("cycles", 64'(cyc), 64'(cpi + (is_mem ? acc_waits : 0)));
            if (is_mem) begin
               chk("mem_we", 64'(acc_we), 64'(e_we));
               chk("mem_addr", 64'(acc_addr), 64'(e_addr));
               if (e_we) chk("mem_wdata", 64'(acc_wdata), 64'(e_wd));
            end
            pc_hist.push_back(int'(pc));
            cyc_hist.push_back(cyc);
            prev_ret = retired;
            cyc = 0;
         end else if (cyc > 40) begin
            chk("retire_timeout", 64'(cyc), 64'(0));
            return;
         end
      end
   endtask

   task automatic check_regs();
      for (int i = 0; i < 64; i++) chk($sformatf("r%0d", i), 64'(dut.regs[i]), 64'(m_reg[i]));
   endtask

   task automatic hold_check();
      repeat (25) @(negedge clk);
      chk("halt_pc", 64'(pc), 64'(m_pc));
      chk("halt_retired", 64'(retired), 64'(m_ret));
      chk("halt_flag", 64'(halted), 64'(1));
   endtask

   initial begin
      int k, r;
      clkreset   = 1'b0;
      dmem_ready = 1'b0;
      dmem_rdata = '0;
      for (int i = 0; i < int'(MW); i++) ram[i] = DW'($urandom);
      for (int i = 0; i < 16; i++) imem2[i] = 32'h7000_0000;
      imem2[0] = fi(1, 1, 0, -1);
      imem2[1] = fi(3, 1, 0, 0);
      imem2[2] = fi(5, 0, 0, 14);

      // Arithmetic and SLT, then HALT
      clear_imem();
      imem[0] = fi(1, 1, 0, 5);
      imem[1] = fi(1, 2, 0, -3);
      imem[2] = fr(3, 1, 2, 0);
      imem[3] = fr(4, 2, 1, 1);
      imem[4] = fr(5, 2, 1, 5);
      imem[5] = fi(6, 0, 0, 0);
      reset_core();
      run(5, 0);
      chk("arith_retired", 64'(retired), 64'(5));
      chk("arith_r3", 64'(dut.regs[3]), 64'(2));
      chk("arith_r4", 64'(dut.regs[4]), 64'(32'hFFFF_FFF8));
      chk("arith_r5", 64'(dut.regs[5]), 64'(1));
      chk("arith_cpi", 64'(cyc_hist[4]), 64'(4));
      run(1, 0);
      check_regs();

      // Store/load with three wait cycles, HALT at pc 4
      clear_imem();
      imem[0] = fi(1, 1, 0, 5);
      imem[1] = fi(3, 1, 0, 8);
      imem[2] = fi(2, 6, 0, 8);
      imem[4] = fi(6, 0, 0, 0);
      reset_core();
      run(10, 3);
      chk("ls_ram8", 64'(ram[8]), 64'(5));
      chk("ls_r6", 64'(dut.regs[6]), 64'(5));
      chk("ls_sw_cycles", 64'(cyc_hist[1]), 64'(7));
      chk("ls_lw_cycles", 64'(cyc_hist[2]), 64'(8));
      chk("halt_at4", 64'(pc), 64'(4));
      hold_check();
      check_regs();

      // Branches, jumps, wrap at pc 63 and r0 write discard
      clear_imem();
      imem[0]  = fi(1, 1, 0, 5);
      imem[1]  = fi(1, 2, 0, 9);
      imem[2]  = fi(5, 0, 0, 10);
      imem[10] = fi(4, 1, 1, 2);
      imem[13] = fi(4, 1, 2, 5);
      imem[14] = fi(5, 0, 0, 40);
      imem[40] = fi(5, 0, 0, 63);
      imem[63] = fi(1, 0, 0, 7);
      reset_core();
      run(8, 0);
      chk("beq_taken", 64'(pc_hist[3]), 64'(13));
      chk("beq_not_taken", 64'(pc_hist[4]), 64'(14));
      chk("jmp40", 64'(pc_hist[5]), 64'(40));
      chk("beq_cycles", 64'(cyc_hist[3]), 64'(3));
      chk("wrap_pc", 64'(pc_hist[7]), 64'(0));
      chk("r0_zero", 64'(dut.regs[0]), 64'(0));

      // Reset asserted while a store waits in MEM
      clear_imem();
      imem[0] = fi(3, 1, 0, 3);
      reset_core();
      dmem_ready = 1'b0;
      k = 0;
      while (!dmem_req && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("mem_req_seen", 64'(dmem_req), 64'(1));
      #2 clkreset = 1'b0;
      #1 chk("req_async_clear", 64'(dmem_req), 64'(0));
      chk("pc_async_clear", 64'(pc), 64'(0));
      @(negedge clk);
      clkreset = 1'b1;
      @(negedge clk);
      chk("pc_after_release", 64'(pc), 64'(0));
      chk("halted_after_release", 64'(halted), 64'(0));

      // Randomized programs with random wait states
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 64; i++) begin
            r = int'($urandom_range(99, 0));
            if (r < 30)      imem[i] = fr($urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(15, 0));
            else if (r < 50) imem[i] = fi(1, $urandom_range(7, 0), $urandom_range(7, 0), int'($urandom));
            else if (r < 62) imem[i] = fi(2, $urandom_range(7, 0), $urandom_range(7, 0), int'($urandom));
            else if (r < 74) imem[i] = fi(3, $urandom_range(7, 0), $urandom_range(7, 0), int'($urandom));
            else if (r < 84) imem[i] = fi(4, $urandom_range(7, 0), $urandom_range(7, 0), int'($urandom));
            else if (r < 89) imem[i] = fi(5, 0, 0, int'($urandom));
            else if (r < 90) imem[i] = fi(6, 0, 0, 0);
            else             imem[i] = fi($urandom_range(15, 7), $urandom_range(63, 0), $urandom_range(63, 0), int'($urandom));
         end
         reset_core();
         run(300, -1);
         check_regs();
         if (m_halt) hold_check();
      end

      // Narrow instance has been running its loop since the last reset
      repeat (20) @(negedge clk);
      chk("w16_r1", 64'(dut2.regs[1]), 64'(16'hFFFF));
      chk("w16_store", 64'(st16), 64'(16'hFFFF));
      chk("w16_store_addr", 64'(st16_addr), 64'(0));
      chk("w16_wrap", 64'(wrap16), 64'(1));
      chk("w16_halted", 64'(halted2), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
